// File: rtl/axis_track_pkg.sv
// axis_track_pkg: shared state, direction and speed-code encodings for the axis tracking controller.
package axis_track_pkg;
  typedef enum logic [2:0] {IDLE, EVAL, DEAD, DRIVE, FAULT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_POS, DIR_NEG} dir_t;
  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_SLOW = 2'b01;
  localparam logic [1:0] SPD_FAST = 2'b10;
endpackage

// File: rtl/axis_track_fsm.sv
// axis_track_fsm: one axis (error, deadband, reversal gap, timed burst); TRACK_TIMEOUT_EN adds the burst-limit fault.
module axis_track_fsm
  import axis_track_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEADBAND   = 4,
  parameter int FAST_THR   = 20,
  parameter int DRIVE_CYC  = 8,
  parameter int DEAD_CYC   = 3,
  parameter int MAX_BURSTS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clr_i,
  input  logic              auto_i,
  input  logic [DATA_W-1:0] sens_a_i,
  input  logic [DATA_W-1:0] sens_b_i,
  input  logic [DATA_W-1:0] target_i,
  input  logic [DATA_W-1:0] actual_i,
  output logic [1:0]        drv_pos_o,
  output logic [1:0]        drv_neg_o,
  output logic              done_o,
  output logic              fault_o,
  output logic              ready_o
);
  localparam int CW = $clog2((DRIVE_CYC > DEAD_CYC ? DRIVE_CYC : DEAD_CYC) + 1);
  state_t            state_q, state_d;
  dir_t              dir_q, dir_d, last_q, last_d, new_dir;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        spd_q, spd_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   err, mag;
  logic              rev, quiet, over;
`ifdef TRACK_TIMEOUT_EN
  localparam int BW = $clog2(MAX_BURSTS + 2);
  logic [BW-1:0] burst_q, burst_d;
  assign over    = burst_q >= BW'(MAX_BURSTS);
  assign fault_o = state_q == FAULT;
  always_comb
    burst_d = (state_q == FAULT && clr_i) ? '0 :
              state_q != EVAL ? burst_q :
              quiet ? '0 : rev ? BW'(1) : over ? burst_q : burst_q + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) burst_q <= '0;
    else burst_q <= burst_d;
`else
  logic unused_max;
  assign unused_max = ^MAX_BURSTS;
  assign over       = 1'b0;
  assign fault_o    = 1'b0;
`endif
  always_comb begin
    err     = {1'b0, a_q} - {1'b0, b_q};
    mag     = err[DATA_W] ? -err : err;
    new_dir = err[DATA_W] ? DIR_NEG : DIR_POS;
    rev     = last_q != DIR_NONE && last_q != new_dir;
    quiet   = mag <= (DATA_W+1)'(DEADBAND);
    state_d = state_q;
    dir_d   = dir_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    spd_d   = spd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = EVAL;
        a_d     = auto_i ? sens_a_i : target_i;
        b_d     = auto_i ? sens_b_i : actual_i;
      end
      EVAL: begin
        dir_d = new_dir;
        spd_d = mag > (DATA_W+1)'(FAST_THR) ? SPD_FAST : SPD_SLOW;
        if (quiet) begin
          state_d = IDLE;
          done_d  = 1'b1;
          last_d  = DIR_NONE;
        end else if (rev) begin
          state_d = DEAD;
          cnt_d   = CW'(DEAD_CYC - 1);
        end else if (over) begin
          state_d = FAULT;
          done_d  = 1'b1;
        end else begin
          state_d = DRIVE;
          cnt_d   = CW'(DRIVE_CYC - 1);
          last_d  = new_dir;
        end
      end
      DEAD: if (cnt_q == '0) begin
        state_d = DRIVE;
        cnt_d   = CW'(DRIVE_CYC - 1);
        last_d  = dir_q;
      end else cnt_d = cnt_q - 1'b1;
      DRIVE: if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      FAULT: if (clr_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      dir_q   <= DIR_NONE;
      last_q  <= DIR_NONE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      spd_q   <= SPD_STOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      spd_q   <= spd_d;
      done_q  <= done_d;
    end
  assign drv_pos_o = (state_q == DRIVE && dir_q == DIR_POS) ? spd_q : SPD_STOP;
  assign drv_neg_o = (state_q == DRIVE && dir_q == DIR_NEG) ? spd_q : SPD_STOP;
  assign done_o    = done_q;
  assign ready_o   = state_q == IDLE || state_q == FAULT;
endmodule

// File: rtl/axis_track_ctrl.sv
// axis_track_ctrl: NUM_AXES tracking controller (handshake, ready reduction, bus slicing); TRACK_TIMEOUT_EN enables fault/fault_clr.
module axis_track_ctrl
  import axis_track_pkg::*;
#(
  parameter int NUM_AXES   = 2,
  parameter int DATA_W     = 16,
  parameter int DEADBAND   = 4,
  parameter int FAST_THR   = 20,
  parameter int DRIVE_CYC  = 8,
  parameter int DEAD_CYC   = 3,
  parameter int MAX_BURSTS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [NUM_AXES-1:0]        auto_mode,
  input  logic [NUM_AXES*DATA_W-1:0] sens_a,
  input  logic [NUM_AXES*DATA_W-1:0] sens_b,
  input  logic [NUM_AXES*DATA_W-1:0] target,
  input  logic [NUM_AXES*DATA_W-1:0] actual,
  input  logic                       fault_clr,
  output logic [2*NUM_AXES-1:0]      drv_pos,
  output logic [2*NUM_AXES-1:0]      drv_neg,
  output logic [NUM_AXES-1:0]        done,
  output logic [NUM_AXES-1:0]        fault
);
  logic [NUM_AXES-1:0] ready;
  logic                clr, accept;
`ifdef TRACK_TIMEOUT_EN
  assign clr = fault_clr;
`else
  logic unused_clr;
  assign unused_clr = fault_clr;
  assign clr        = 1'b0;
`endif
  assign sample_ready = &ready;
  // a clear takes priority; the pending sample is accepted on a later edge
  assign accept = sample_valid & sample_ready & ~clr;
  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    axis_track_fsm #(
      .DATA_W(DATA_W), .DEADBAND(DEADBAND), .FAST_THR(FAST_THR),
      .DRIVE_CYC(DRIVE_CYC), .DEAD_CYC(DEAD_CYC), .MAX_BURSTS(MAX_BURSTS)
    ) u_fsm (
      .clk(clk),
      .rst(rst),
      .start_i(accept),
      .clr_i(clr),
      .auto_i(auto_mode[i]),
      .sens_a_i(sens_a[i*DATA_W +: DATA_W]),
      .sens_b_i(sens_b[i*DATA_W +: DATA_W]),
      .target_i(target[i*DATA_W +: DATA_W]),
      .actual_i(actual[i*DATA_W +: DATA_W]),
      .drv_pos_o(drv_pos[2*i +: 2]),
      .drv_neg_o(drv_neg[2*i +: 2]),
      .done_o(done[i]),
      .fault_o(fault[i]),
      .ready_o(ready[i])
    );
  end
endmodule

// File: tb/tb_axis_track_ctrl.sv
// tb_axis_track_ctrl: vector table with a cycle-accurate scoreboard plus reset and timeout sequences.
module tb_axis_track_ctrl;
  localparam int NA = 2;
  localparam int DW = 16;
  localparam int DRV = 8;
  localparam int DED = 3;
  typedef struct {
    logic [1:0] am;
    int a0, b0, c0, d0, a1, b1, c1, d1;
  } vec_t;
  typedef struct {
    logic [3:0] pos, neg;
    logic [1:0] done, fault;
    logic rdy;
  } exp_t;
  logic clk = 0, rst = 1, sample_valid = 0, fault_clr = 0, sample_ready;
  logic [NA-1:0] auto_mode = '0, done, fault;
  logic [NA*DW-1:0] sens_a = '0, sens_b = '0, target = '0, actual = '0;
  logic [2*NA-1:0] drv_pos, drv_neg;
  exp_t sb[$];
  vec_t tab[10];
  int n_vec = 0, n_bad = 0;
  int last[2] = '{0, 0};
  always #5 clk = ~clk;
  axis_track_ctrl #(
    .NUM_AXES(NA), .DATA_W(DW), .DEADBAND(4), .FAST_THR(20),
    .DRIVE_CYC(DRV), .DEAD_CYC(DED), .MAX_BURSTS(3)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .auto_mode(auto_mode), .sens_a(sens_a), .sens_b(sens_b), .target(target),
    .actual(actual), .fault_clr(fault_clr), .drv_pos(drv_pos), .drv_neg(drv_neg),
    .done(done), .fault(fault)
  );
  always @(negedge clk)
    if (rst)
      for (int i = 0; i < NA; i++) begin
        n_vec++;
        if ((drv_pos[2*i +: 2] != 2'b00 && drv_neg[2*i +: 2] != 2'b00) ||
            drv_pos[2*i +: 2] == 2'b11 || drv_neg[2*i +: 2] == 2'b11) begin
          n_bad++;
          $display("FAIL interlock axis%0d: pos=%b neg=%b, required no overlap and no 2'b11",
                   i, drv_pos[2*i +: 2], drv_neg[2*i +: 2]);
        end
      end
  task automatic check_out(string nm, exp_t e);
    n_vec++;
    if (drv_pos !== e.pos || drv_neg !== e.neg || done !== e.done || fault !== e.fault || sample_ready !== e.rdy) begin
      n_bad++;
      $display("FAIL %s: got pos=%b neg=%b done=%b fault=%b rdy=%b, want pos=%b neg=%b done=%b fault=%b rdy=%b",
               nm, drv_pos, drv_neg, done, fault, sample_ready, e.pos, e.neg, e.done, e.fault, e.rdy);
    end
  endtask
  task automatic wait_ready();
    int t = 0;
    while (sample_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sample_ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: sample_ready=%b after %0d cycles, want 1", sample_ready, t);
    end
  endtask
  task automatic drive_words(vec_t v);
    int a[2], b[2];
    a[0] = v.a0; b[0] = v.b0; a[1] = v.a1; b[1] = v.b1;
    for (int i = 0; i < NA; i++) begin
      sens_a[i*DW +: DW] = v.am[i] ? DW'(a[i]) : DW'(b[i]);
      sens_b[i*DW +: DW] = v.am[i] ? DW'(b[i]) : DW'(a[i]);
      target[i*DW +: DW] = v.am[i] ? DW'(b[i]) : DW'(a[i]);
      actual[i*DW +: DW] = v.am[i] ? DW'(a[i]) : DW'(b[i]);
    end
    auto_mode = v.am;
  endtask
  task automatic model(vec_t v, output int len);
    int c[2], d[2], lo[2], hi[2], dk[2], gap;
    exp_t e;
    c[0] = v.c0; c[1] = v.c1; d[0] = v.d0; d[1] = v.d1;
    for (int i = 0; i < NA; i++)
      if (d[i] == 0) begin
        dk[i] = 1; lo[i] = 1; hi[i] = 0; last[i] = 0;
      end else begin
        gap = (last[i] != 0 && last[i] != d[i]) ? DED : 0;
        lo[i] = 1 + gap; hi[i] = DRV + gap; dk[i] = DRV + 1 + gap; last[i] = d[i];
      end
    len = (dk[0] > dk[1] ? dk[0] : dk[1]) + 1;
    for (int k = 0; k < len; k++) begin
      e = '{default: 0};
      for (int i = 0; i < NA; i++) begin
        if (k >= lo[i] && k <= hi[i]) begin
          if (d[i] > 0) e.pos[2*i +: 2] = 2'(c[i]);
          else e.neg[2*i +: 2] = 2'(c[i]);
        end
        e.done[i] = k == dk[i];
      end
      e.rdy = k >= dk[0] && k >= dk[1];
      sb.push_back(e);
    end
  endtask
  task automatic apply(vec_t v, string nm);
    int len;
    wait_ready();
    drive_words(v);
    sample_valid = 1'b1;
    model(v, len);
    @(posedge clk);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) begin
        sample_valid = 1'b0;
        sens_a = $urandom; sens_b = $urandom; target = $urandom; actual = $urandom;
        auto_mode = 2'($urandom);
      end
      check_out($sformatf("%s k=%0d", nm, k), sb.pop_front());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t r;
    exp_t e;
    tab[0] = '{2'b11, 30, 5, 2, 1, 7, 7, 0, 0};
    tab[1] = '{2'b00, 3, 3, 0, 0, 35, 45, 1, -1};
    tab[2] = '{2'b01, 14, 10, 0, 0, 10, 14, 0, 0};
    tab[3] = '{2'b11, 15, 10, 1, 1, 0, 65535, 2, -1};
    tab[4] = '{2'b10, 30, 10, 1, 1, 10, 30, 1, -1};
    tab[5] = '{2'b11, 31, 10, 2, 1, 31, 10, 2, 1};
    tab[6] = '{2'b00, 0, 10, 1, -1, 5, 5, 0, 0};
    tab[7] = '{2'b01, 6, 10, 0, 0, 10, 6, 0, 0};
    tab[8] = '{2'b11, 65535, 0, 2, 1, 10, 31, 2, -1};
    tab[9] = '{2'b10, 0, 10, 1, -1, 10, 30, 1, -1};
    #1 rst = 1'b0;
    #1 check_out("reset_state", '{pos: 4'h0, neg: 4'h0, done: 2'b00, fault: 2'b00, rdy: 1'b1});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 10; n++) apply(tab[n], $sformatf("vec%0d", n));
    r = '{2'b11, 15, 5, 1, 1, 7, 7, 0, 0};
    wait_ready();
    drive_words(r);
    sample_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
    n_vec++;
    if (drv_pos !== 4'b0001) begin
      n_bad++;
      $display("FAIL rst_pre_burst: got pos=%b, want 0001", drv_pos);
    end
    #2 rst = 1'b0;
    #1 check_out("rst_async", '{pos: 4'h0, neg: 4'h0, done: 2'b00, fault: 2'b00, rdy: 1'b1});
    @(negedge clk);
    rst = 1'b1;
    last[0] = 0; last[1] = 0;
    apply('{2'b11, 0, 10, 1, -1, 7, 7, 0, 0}, "post_rst_no_gap");
`ifdef TRACK_TIMEOUT_EN
    r = '{2'b11, 15, 5, 1, 1, 5, 5, 0, 0};
    apply('{2'b11, 5, 5, 0, 0, 5, 5, 0, 0}, "to_clear");
    for (int n = 0; n < 3; n++) apply(r, $sformatf("to_burst%0d", n));
    wait_ready();
    drive_words(r);
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    check_out("to_eval", '{pos: 4'h0, neg: 4'h0, done: 2'b00, fault: 2'b00, rdy: 1'b0});
    @(negedge clk);
    check_out("to_fault", '{pos: 4'h0, neg: 4'h0, done: 2'b11, fault: 2'b01, rdy: 1'b1});
    @(negedge clk);
    check_out("to_sticky", '{pos: 4'h0, neg: 4'h0, done: 2'b00, fault: 2'b01, rdy: 1'b1});
    fault_clr = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fault_clr = 1'b0;
    sample_valid = 1'b0;
    check_out("to_clr_wins", '{pos: 4'h0, neg: 4'h0, done: 2'b00, fault: 2'b00, rdy: 1'b1});
    apply(r, "to_after_clr");
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
